// File: rtl/pcs_tx_xmit_void_if.sv
// Bus between the PCS transmit ordered-set FSM and pcs_tx_xmit_void_unit.
// All per-channel fields are flat vectors, lane i at [i*W +: W].
interface pcs_tx_xmit_void_if #(
    parameter int NCH    = 1,
    parameter int OS_W   = 9,
    parameter int XMIT_W = 3,
    parameter int CNT_W  = 16
);
    logic [NCH*XMIT_W-1:0] xmit;
    logic [NCH-1:0]        xmit_change_clr;
    logic [NCH-1:0]        tx_en;
    logic [NCH-1:0]        tx_er;
    logic [NCH*8-1:0]      txd;
    logic [NCH*OS_W-1:0]   os_in;
    logic [NCH-1:0]        os_valid_in;
    logic [NCH*OS_W-1:0]   os_out;
    logic [NCH-1:0]        os_valid_out;
    logic [NCH-1:0]        xmit_change;
    logic [NCH*CNT_W-1:0]  void_cnt;

    modport master (
        output xmit, xmit_change_clr, tx_en, tx_er, txd, os_in, os_valid_in,
        input  os_out, os_valid_out, xmit_change, void_cnt
    );
    modport slave (
        input  xmit, xmit_change_clr, tx_en, tx_er, txd, os_in, os_valid_in,
        output os_out, os_valid_out, xmit_change, void_cnt
    );
endinterface

// File: rtl/pcs_tx_xmit_void_unit.sv
// Per-channel sticky xmit-change flag, registered VOID(x) substitution and /V/ counter.
// Optional feature: define PCS_VOID_CNT_EN to build the saturating /V/ counters.
module pcs_tx_xmit_void_lane #(
    parameter int                OS_W     = 9,
    parameter int                XMIT_W   = 3,
    parameter logic [XMIT_W-1:0] XMIT_RST = 3'b001,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XMIT_W-1:0] xmit,
    input  logic              xmit_change_clr,
    input  logic              tx_en,
    input  logic              tx_er,
    input  logic [7:0]        txd,
    input  logic [OS_W-1:0]   os_in,
    input  logic              os_valid_in,
    output logic [OS_W-1:0]   os_out,
    output logic              os_valid_out,
    output logic              xmit_change,
    output logic [CNT_W-1:0]  void_cnt
);
    localparam logic [OS_W-1:0] OS_I = OS_W'(9'h008);
    localparam logic [OS_W-1:0] OS_V = OS_W'(9'h040);
    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_CHANGED = 1'b1;

    logic [XMIT_W-1:0] xmit_old;
    logic [0:0]        state, state_nxt;
    logic              void_sel;
    logic [1:0]        vld_pipe;

    // Carrier extend (TX_EN=0, TX_ER=1, TXD=0F) is legal and must not be voided.
    assign void_sel = tx_er & (tx_en | (txd != 8'h0F));

    always_comb begin
        state_nxt = state;
        if (xmit != xmit_old)
            state_nxt = ST_CHANGED;
        else if (state == ST_CHANGED && xmit_change_clr)
            state_nxt = ST_STABLE;
    end

    always_comb vld_pipe[0] = os_valid_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmit_old    <= XMIT_RST;
            state       <= ST_STABLE;
            os_out      <= OS_I;
            vld_pipe[1] <= 1'b0;
        end else begin
            xmit_old    <= xmit;
            state       <= state_nxt;
            os_out      <= void_sel ? OS_V : os_in;
            vld_pipe[1] <= vld_pipe[0];
        end
    end

    assign xmit_change  = (state == ST_CHANGED);
    assign os_valid_out = vld_pipe[1];

`ifdef PCS_VOID_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (os_valid_in && void_sel && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end
    assign void_cnt = cnt;
`else
    assign void_cnt = '0;
`endif
endmodule

module pcs_tx_xmit_void_unit #(
    parameter int                NCH      = 1,
    parameter int                OS_W     = 9,
    parameter int                XMIT_W   = 3,
    parameter logic [XMIT_W-1:0] XMIT_RST = 3'b001,
    parameter int                CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    pcs_tx_xmit_void_if.slave bus
);
    logic [NCH-1:0][OS_W-1:0]  os_out_l;
    logic [NCH-1:0]            os_valid_out_l;
    logic [NCH-1:0]            xmit_change_l;
    logic [NCH-1:0][CNT_W-1:0] void_cnt_l;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        pcs_tx_xmit_void_lane #(
            .OS_W(OS_W), .XMIT_W(XMIT_W), .XMIT_RST(XMIT_RST), .CNT_W(CNT_W)
        ) u_lane (
            .clk            (clk),
            .rst_n          (rst_n),
            .xmit           (bus.xmit[i*XMIT_W +: XMIT_W]),
            .xmit_change_clr(bus.xmit_change_clr[i]),
            .tx_en          (bus.tx_en[i]),
            .tx_er          (bus.tx_er[i]),
            .txd            (bus.txd[i*8 +: 8]),
            .os_in          (bus.os_in[i*OS_W +: OS_W]),
            .os_valid_in    (bus.os_valid_in[i]),
            .os_out         (os_out_l[i]),
            .os_valid_out   (os_valid_out_l[i]),
            .xmit_change    (xmit_change_l[i]),
            .void_cnt       (void_cnt_l[i])
        );
    end

    assign bus.os_out       = os_out_l;
    assign bus.os_valid_out = os_valid_out_l;
    assign bus.xmit_change  = xmit_change_l;
    assign bus.void_cnt     = void_cnt_l;
endmodule

// File: tb/tb_pcs_tx_xmit_void_unit.sv
// Randomized + directed bench for pcs_tx_xmit_void_unit against a per-channel reference model.
module tb_pcs_tx_xmit_void_unit;
    localparam int NCH = 4, OS_W = 9, XMIT_W = 3, CNT_W = 4;
    localparam logic [XMIT_W-1:0] XMIT_RST = 3'b001;
`ifdef PCS_VOID_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcs_tx_xmit_void_if #(.NCH(NCH), .OS_W(OS_W), .XMIT_W(XMIT_W), .CNT_W(CNT_W)) bus();

    pcs_tx_xmit_void_unit #(
        .NCH(NCH), .OS_W(OS_W), .XMIT_W(XMIT_W), .XMIT_RST(XMIT_RST), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [XMIT_W-1:0] m_old  [NCH];
    bit                m_flag [NCH];
    logic [OS_W-1:0]   m_os   [NCH];
    bit                m_vld  [NCH];
    int                m_cnt  [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_old[i] = XMIT_RST; m_flag[i] = 0; m_os[i] = 9'h008; m_vld[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("os_out[%0d]", i),       32'(bus.os_out[i*OS_W +: OS_W]),    32'(m_os[i]));
            chk($sformatf("os_valid_out[%0d]", i), 32'(bus.os_valid_out[i]),          32'(m_vld[i]));
            chk($sformatf("xmit_change[%0d]", i),  32'(bus.xmit_change[i]),           32'(m_flag[i]));
            chk($sformatf("void_cnt[%0d]", i),     32'(bus.void_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
        end
    endtask

    task automatic set_ch(input int i, input logic [XMIT_W-1:0] x, input bit clr, input bit en,
                          input bit er, input logic [7:0] d, input logic [OS_W-1:0] os, input bit vld);
        bus.xmit[i*XMIT_W +: XMIT_W] = x;
        bus.xmit_change_clr[i] = clr;
        bus.tx_en[i] = en;
        bus.tx_er[i] = er;
        bus.txd[i*8 +: 8] = d;
        bus.os_in[i*OS_W +: OS_W] = os;
        bus.os_valid_in[i] = vld;
    endtask

    // Apply current inputs for one clock, advance the model, check outputs after the edge.
    task automatic step();
        logic [XMIT_W-1:0] x;
        logic [7:0] d;
        bit vsub;
        for (int i = 0; i < NCH; i++) begin
            x = bus.xmit[i*XMIT_W +: XMIT_W];
            d = bus.txd[i*8 +: 8];
            vsub = bus.tx_er[i] && (bus.tx_en[i] || d != 8'h0F);
            if (x != m_old[i]) m_flag[i] = 1;
            else if (bus.xmit_change_clr[i]) m_flag[i] = 0;
            m_old[i] = x;
            m_os[i]  = vsub ? 9'h040 : bus.os_in[i*OS_W +: OS_W];
            m_vld[i] = bus.os_valid_in[i];
            if (CNT_EN && bus.os_valid_in[i] && vsub && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset between edges and check that outputs clear without waiting for a clock.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) set_ch(i, XMIT_RST, 0, 0, 0, 8'h00, 9'h008, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        #4 rst_n = 1'b1;
        step();

        // xmit change on ch0, hold, clear, then change together with clear
        set_ch(0, 3'b010, 0, 0, 0, 8'h00, 9'h008, 1);
        step(); chk("chg_set", 32'(bus.xmit_change[0]), 1);
        repeat (3) step();
        chk("chg_hold", 32'(bus.xmit_change[0]), 1);
        bus.xmit_change_clr[0] = 1;
        step(); chk("chg_clr", 32'(bus.xmit_change[0]), 0);
        bus.xmit[0 +: XMIT_W] = 3'b100;
        step(); chk("chg_set_wins", 32'(bus.xmit_change[0]), 1);
        step(); chk("chg_clr2", 32'(bus.xmit_change[0]), 0);

        // VOID matrix on ch0
        set_ch(0, 3'b100, 0, 1, 1, 8'h00, 9'h010, 1);
        step(); chk("void_en_er", 32'(bus.os_out[0 +: OS_W]), 32'h040);
        set_ch(0, 3'b100, 0, 0, 1, 8'h0F, 9'h010, 1);
        step(); chk("void_carrier_ext", 32'(bus.os_out[0 +: OS_W]), 32'h010);
        set_ch(0, 3'b100, 0, 0, 1, 8'h1F, 9'h010, 1);
        step(); chk("void_er_only", 32'(bus.os_out[0 +: OS_W]), 32'h040);
        set_ch(0, 3'b100, 0, 1, 0, 8'h1F, 9'h010, 1);
        step(); chk("void_no_er", 32'(bus.os_out[0 +: OS_W]), 32'h010);
        set_ch(0, 3'b100, 0, 0, 0, 8'h00, 9'h1A5, 0);
        step(); chk("passthru_nonhot", 32'(bus.os_out[0 +: OS_W]), 32'h1A5);

        // counter saturation on ch1, then /V/ without valid must not count
        set_ch(1, XMIT_RST, 0, 1, 1, 8'h55, 9'h010, 1);
        repeat (20) step();
        chk("cnt_sat", 32'(bus.void_cnt[1*CNT_W +: CNT_W]), CNT_EN ? 32'd15 : 32'd0);
        mid_reset();
        set_ch(1, XMIT_RST, 0, 1, 1, 8'h55, 9'h010, 1);
        repeat (3) step();
        bus.os_valid_in[1] = 0;
        repeat (3) step();
        chk("cnt_novalid", 32'(bus.void_cnt[1*CNT_W +: CNT_W]), CNT_EN ? 32'd3 : 32'd0);

        // multichannel: errors on ch2 only, xmit change on ch0 only
        for (int i = 0; i < NCH; i++) set_ch(i, 3'b010, 1, 0, 0, 8'h00, 9'h010, 1);
        repeat (2) step();
        for (int i = 0; i < NCH; i++) set_ch(i, 3'b010, 0, 0, 0, 8'h00, 9'h010, 1);
        set_ch(2, 3'b010, 0, 1, 1, 8'h00, 9'h010, 1);
        bus.xmit[0 +: XMIT_W] = 3'b100;
        step();
        chk("mc_xmit_change", 32'(bus.xmit_change), 32'b0001);
        chk("mc_ch2_void", 32'(bus.os_out[2*OS_W +: OS_W]), 32'h040);
        chk("mc_ch3_pass", 32'(bus.os_out[3*OS_W +: OS_W]), 32'h010);

        // randomized traffic with a reset in the middle
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(9) == 0) bus.xmit[i*XMIT_W +: XMIT_W] = XMIT_W'($urandom_range(7));
                bus.xmit_change_clr[i] = ($urandom_range(3) == 0);
                bus.tx_en[i] = $urandom_range(1) == 1;
                bus.tx_er[i] = $urandom_range(2) == 0;
                bus.txd[i*8 +: 8] = ($urandom_range(1) == 1) ? 8'h0F : 8'($urandom);
                bus.os_in[i*OS_W +: OS_W] = OS_W'($urandom);
                bus.os_valid_in[i] = $urandom_range(3) != 0;
            end
            if (n == 200) mid_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
